// File: rtl/alu_result_queue.sv
// alu_result_queue: in-order ALU result FIFO feeding the register file, owning NZP and evaluating BR.
// Optional `CC_FORWARD_EN lets the branch check see the youngest pending CC instead of only committed NZP.
module alu_result_queue #(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 3,
  parameter int DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  logic [REG_BITS-1:0]      in_dr,
  input  logic                     in_ld_reg,
  input  logic                     in_set_cc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     rf_we,
  output logic [REG_BITS-1:0]      rf_addr,
  output logic [WIDTH-1:0]         rf_data,
  input  logic                     flush,
  input  logic [2:0]               br_nzp,
  output logic                     br_taken,
  output logic [2:0]               nzp,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [WIDTH-1:0]    r_result [DEPTH];
  logic [REG_BITS-1:0] r_dr [DEPTH];
  logic [2:0]          r_cc [DEPTH];
  logic [DEPTH-1:0]    r_ld, r_scc;
  logic [AW-1:0]       r_wr, r_rd;
  logic [CW-1:0]       r_count;
  logic [2:0]          r_nzp, w_nzp_eff, w_cc_in;
  logic                w_push, w_pop, w_zero;
  assign in_ready  = r_count != FULL;
  assign out_valid = r_count != '0;
  // flush wins over both handshakes: nothing enters, nothing retires
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;
  assign w_zero    = in_result == '0;
  assign w_cc_in   = {in_result[WIDTH-1], w_zero, ~in_result[WIDTH-1] & ~w_zero};
  assign rf_we     = w_pop & r_ld[r_rd] & reset_n;
  assign rf_addr   = r_dr[r_rd];
  assign rf_data   = r_result[r_rd];
  assign nzp       = r_nzp;
  assign count     = r_count;
  assign br_taken  = |(br_nzp & w_nzp_eff);
  always_ff @(posedge clk)
    if (w_push) begin
      r_result[r_wr] <= in_result;
      r_dr[r_wr]     <= in_dr;
      r_cc[r_wr]     <= w_cc_in;
      r_ld[r_wr]     <= in_ld_reg;
      r_scc[r_wr]    <= in_set_cc;
    end
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= r_rd + AW'(w_pop);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
    if (!reset_n) r_nzp <= 3'b010;
    else if (w_pop && r_scc[r_rd]) r_nzp <= r_cc[r_rd];
  end
`ifdef CC_FORWARD_EN
  // walk oldest to youngest so the last matching entry wins
  always_comb begin
    w_nzp_eff = r_nzp;
    for (int i = 0; i < DEPTH; i++)
      w_nzp_eff = (!flush && CW'(i) < r_count && r_scc[r_rd + AW'(i)]) ? r_cc[r_rd + AW'(i)] : w_nzp_eff;
  end
`else
  assign w_nzp_eff = r_nzp;
`endif
endmodule

// File: tb/tb_alu_result_queue.sv
// tb_alu_result_queue: scoreboard bench; the driver queues expected retirements, a monitor pops and checks them.
module tb_alu_result_queue;
  localparam int DEPTH = 2;
  logic clk, reset_n, in_valid, in_ready, in_ld_reg, in_set_cc, out_valid, out_ready;
  logic rf_we, flush, br_taken;
  logic [15:0] in_result, rf_data;
  logic [2:0] in_dr, rf_addr, br_nzp, nzp;
  logic [1:0] count;
  typedef struct {logic [15:0] res; logic [2:0] dr; bit ld; bit sc;} ent_t;
  ent_t sb[$];
  int total = 0, bad = 0, exp_cnt = 0;
  logic exp_br = 0;
  logic [2:0] nzp_m = 3'b010;
  alu_result_queue dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_dr(in_dr), .in_ld_reg(in_ld_reg), .in_set_cc(in_set_cc),
    .out_valid(out_valid), .out_ready(out_ready), .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_data(rf_data), .flush(flush), .br_nzp(br_nzp), .br_taken(br_taken),
    .nzp(nzp), .count(count)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [2:0] cc_of(logic [15:0] r);
    return r[15] ? 3'b100 : (r == 0) ? 3'b010 : 3'b001;
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 0; in_valid = 1; out_ready = 1; flush = 0;
    sb.delete();
    nzp_m = 3'b010;
  endtask
  task automatic drive(bit v, logic [15:0] r, logic [2:0] d, bit ld, bit sc, bit ordy, bit fl, logic [2:0] b);
    logic [2:0] eff;
    @(negedge clk);
    reset_n = 1; in_valid = v; in_result = r; in_dr = d; in_ld_reg = ld; in_set_cc = sc;
    out_ready = ordy; flush = fl; br_nzp = b;
    exp_cnt = sb.size();
    eff = nzp_m;
`ifdef CC_FORWARD_EN
    if (!fl) foreach (sb[i]) if (sb[i].sc) eff = cc_of(sb[i].res);
`endif
    exp_br = |(b & eff);
    if (v && sb.size() < DEPTH && !fl) sb.push_back('{r, d, ld, sc});
  endtask
  // monitor: checks the cycle the driver just set up, then retires the head into the model
  initial forever begin
    ent_t e;
    @(negedge clk); #2;
    if (!reset_n) chk("rst_rf_we", rf_we, 0);
    else begin
      chk("count", count, exp_cnt);
      chk("in_ready", in_ready, exp_cnt != DEPTH);
      chk("out_valid", out_valid, exp_cnt != 0);
      chk("nzp", nzp, nzp_m);
      chk("br_taken", br_taken, exp_br);
      if (exp_cnt != 0 && out_ready && !flush) begin
        e = sb.pop_front();
        chk("rf_we", rf_we, e.ld);
        chk("rf_addr", rf_addr, e.dr);
        chk("rf_data", rf_data, e.res);
        if (e.sc) nzp_m = cc_of(e.res);
      end else chk("rf_we_idle", rf_we, 0);
      if (flush) sb.delete();
    end
  end
  initial begin
    reset_n = 0; in_valid = 0; in_result = 0; in_dr = 0; in_ld_reg = 0; in_set_cc = 0;
    out_ready = 0; flush = 0; br_nzp = 0;
    do_reset(); do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 3'b010);
    #1;
    chk("rst_nzp", nzp, 3'b010);
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_br_taken", br_taken, 1);
    drive(1, 16'h8000, 3, 1, 1, 1, 0, 3'b111);
    drive(0, 0, 0, 0, 0, 1, 0, 3'b000);
    #3;
    chk("neg_rf_we", rf_we, 1);
    chk("neg_rf_addr", rf_addr, 3);
    chk("neg_rf_data", rf_data, 16'h8000);
    drive(0, 0, 0, 0, 0, 1, 0, 3'b100);
    #3;
    chk("neg_nzp", nzp, 3'b100);
    drive(1, 16'h0001, 1, 1, 1, 0, 0, 3'b001);
    drive(1, 16'h0000, 2, 1, 1, 0, 0, 3'b010);
    drive(1, 16'h1234, 5, 1, 1, 0, 0, 3'b000);
    #3;
    chk("full_count", count, 2);
    chk("full_in_ready", in_ready, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 3'b001);
    drive(0, 0, 0, 0, 0, 1, 0, 3'b010);
    #3;
    chk("stall_nzp1", nzp, 3'b001);
    drive(0, 0, 0, 0, 0, 1, 0, 3'b010);
    #3;
    chk("stall_nzp2", nzp, 3'b010);
    for (int k = 0; k < 7; k++) drive(1, 16'(16'h100 + k), 3'(k), 1, k[0], 1, 0, 3'b111);
    drive(0, 0, 0, 0, 0, 1, 0, 3'b000);
    drive(1, 16'h7777, 4, 1, 1, 0, 0, 3'b000);
    drive(1, 16'hF000, 6, 0, 1, 0, 0, 3'b000);
    drive(1, 16'h0042, 7, 1, 1, 1, 1, 3'b111);
    #3;
    chk("flush_rf_we", rf_we, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 3'b000);
    #3;
    chk("flush_count", count, 0);
    do_reset();
    drive(1, 16'hFFFF, 1, 1, 1, 0, 0, 3'b000);
    drive(0, 0, 0, 0, 0, 0, 0, 3'b100);
    #3;
`ifdef CC_FORWARD_EN
    chk("fwd_br_taken", br_taken, 1);
`else
    chk("fwd_br_taken", br_taken, 0);
`endif
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else drive($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
                 3'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, 3'($urandom));
    end
    drive(0, 0, 0, 0, 0, 1, 0, 3'b000);
    @(negedge clk); #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
